// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits exactly F evenly spaced rising edges per gate window via a phase accumulator
module pulse_train_gen #(
   parameter int WIN_SHORT = 10000,
   parameter int LONG_MULT = 100,
   parameter int FW        = 16,
   parameter int ACCW      = 21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          mode_i,
   input  logic [FW-1:0] f_i,
   output logic          pulse_out_o,
   output logic          win_tick_o,
   output logic [FW-1:0] factive_o,
   output logic          clamped_o
);
   localparam logic [ACCW-1:0] WS = ACCW'(WIN_SHORT);
   localparam logic [ACCW-1:0] WL = ACCW'(WIN_SHORT * LONG_MULT);
   logic [ACCW-1:0] wcnt_q, wcnt_d, acc_q, acc_d;
   logic [ACCW-1:0] win, fmax, f_ext, step2, base, t;
   logic [FW-1:0]   factive_q, factive_d;
   logic            pulse_q, pulse_d, mode_q, mode_d, clamped_q, clamped_d;
   logic            first, wrap;
   // cycle 0 samples the request and restarts the phase; every cycle accumulates 2F against WIN
   always_comb begin
      first     = (wcnt_q == '0);
      mode_d    = first ? mode_i : mode_q;
      win       = mode_d ? WL : WS;
      fmax      = win >> 1;
      f_ext     = ACCW'(f_i);
      clamped_d = first ? (en_i && f_ext > fmax) : clamped_q;
      factive_d = first ? (en_i ? (clamped_d ? FW'(fmax) : f_i) : '0) : factive_q;
      step2     = ACCW'(factive_d) << 1;
      base      = first ? '0 : acc_q;
      t         = base + step2;
      wrap      = (t >= win);
      acc_d     = wrap ? t - win : t;
      pulse_d   = wrap ? ~pulse_q : pulse_q;
      wcnt_d    = (wcnt_q == win - ACCW'(1)) ? '0 : wcnt_q + ACCW'(1);
   end
   // state registers; reset aborts the window and lands on cycle 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q    <= '0;
         acc_q     <= '0;
         pulse_q   <= 1'b0;
         mode_q    <= 1'b0;
         clamped_q <= 1'b0;
         factive_q <= '0;
      end else begin
         wcnt_q    <= wcnt_d;
         acc_q     <= acc_d;
         pulse_q   <= pulse_d;
         mode_q    <= mode_d;
         clamped_q <= clamped_d;
         factive_q <= factive_d;
      end
   end
   assign pulse_out_o = pulse_q;
   assign win_tick_o  = first;
   assign factive_o   = factive_q;
   assign clamped_o   = clamped_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: randomized check of pulse_train_gen against a per-window arithmetic model
module tb_pulse_train_gen;
   localparam int WS = 200, LM = 5, FW = 16, ACCW = 21, WL = WS * LM;
   logic          clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0;
   logic [FW-1:0] f = '0;
   logic          pulse_out, win_tick, clamped;
   logic [FW-1:0] factive;
   int errs = 0, checks = 0;
   int mk = 0, mw = WS, mfa = 0, ecnt = 0;
   bit mcl = 0, mrst = 1, eok = 0, pprev = 0;

   pulse_train_gen #(.WIN_SHORT(WS), .LONG_MULT(LM), .FW(FW), .ACCW(ACCW)) dut (
      .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .f_i(f),
      .pulse_out_o(pulse_out), .win_tick_o(win_tick), .factive_o(factive), .clamped_o(clamped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d (k=%0d t=%0t)", tag, got, exp, mk, $time);
      end
   endtask

   // window model: the pulse level at window cycle k is the parity of floor(k*2F/WIN)
   task automatic step();
      if (rst) begin
         mk = 0; mw = WS; mfa = 0; mcl = 0; eok = 0;
      end else begin
         if (mk == 0) begin
            mw  = mode ? WL : WS;
            mcl = en && (int'(f) > mw / 2);
            mfa = !en ? 0 : (mcl ? mw / 2 : int'(f));
         end
         mk = (mk + 1 == mw) ? 0 : mk + 1;
      end
      mrst = rst;
      @(negedge clk);
      check("tick", longint'(win_tick), longint'(mk == 0));
      check("pulse", longint'(pulse_out), (longint'(mk) * 2 * mfa / mw) % 2);
      check("factive", longint'(factive), longint'(mfa));
      check("clamped", longint'(clamped), longint'(mcl));
      if (pulse_out && !pprev) ecnt++;
      pprev = pulse_out;
      if (mk == 0 && !mrst) begin
         if (eok) check("edges", ecnt, mfa);
         eok = 1; ecnt = 0;
      end
   endtask

   task automatic run_to(input int k, input bit pert);
      int n = 0;
      do begin
         if (pert && mk != 0 && $urandom_range(0, 49) == 0) begin
            f = FW'($urandom); en = 1'($urandom); mode = 1'($urandom);
         end
         step();
         n++;
      end while (mk != k && n < 2 * WL);
      check("bound", longint'(mk), longint'(k));
   endtask

   task automatic run_win(input int n, input bit pert);
      for (int i = 0; i < n; i++) run_to(0, pert);
   endtask

   initial begin
      bit found;
      int n;
      rst = 1; step(); step();
      rst = 0; en = 1; mode = 0; f = 25;
      run_win(2, 0);
      f = 100; run_win(2, 0);
      f = 150; run_win(1, 0);
      f = 3;   run_win(2, 0);
      mode = 1; f = 16'hFFFF; run_win(1, 0);
      f = 333; run_win(1, 0);
      mode = 0; en = 0; f = 40; run_win(1, 0);
      en = 1; f = 25; run_to(80, 0);
      f = 50; run_to(0, 0);
      run_win(1, 0);
      run_to(60, 0);
      en = 0; run_to(0, 0);
      run_win(1, 0);
      en = 1; f = 10; found = 0; n = 0;
      while (!found && n < 4 * WS) begin
         step(); n++;
         found = pulse_out && mk > 50;
      end
      check("t6_high", longint'(found), 1);
      rst = 1; step();
      rst = 0; run_win(1, 0);
      for (int w = 0; w < 20; w++) begin
         mode = ($urandom_range(0, 3) == 0);
         en   = ($urandom_range(0, 5) != 0);
         case ($urandom_range(0, 4))
            0: f = '0;
            1: f = FW'($urandom_range(1, 5));
            2: f = FW'($urandom_range(1, (mode ? WL : WS) / 2));
            3: f = FW'((mode ? WL : WS) / 2);
            default: f = FW'($urandom_range((mode ? WL : WS) / 2 + 1, 65535));
         endcase
         run_win(1, 1);
      end
      en = 1; mode = 0; f = 7; run_win(2, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
